db_mem_bridge: RTL and testbench
================================

// Module: db_mem_bridge
// PURPOSE
//  Data-bus slave that sits directly downstream of the CPU/MMU pair. It consumes physical
//  db_addr, db_accessType and db_memLen, performs one access on a 32-bit word-wide memory
//  with req/ack handshake and byte enables, and returns read data plus a db_ready pulse.
//  It does byte/half lane steering, misalignment detection and optional bus-timeout recovery.
// PARAMETERS
//  ADDR_WIDTH      16   byte-address bits decoded; mem_addr = db_addr[ADDR_WIDTH-1:2], upper bits ignored (alias)
//  TIMEOUT_CYCLES  255  WAIT cycles before a timeout abort (only with BUS_TIMEOUT_EN)
// PORTS
//  clk            in   1             clock, all logic on posedge
//  res            in   1             reset, synchronous, active-low
//  db_addr        in   32            physical byte address, held stable while request active
//  db_dataOut     in   32            CPU write data, right-aligned (byte in [7:0], half in [15:0])
//  db_accessType  in   `MEM_ACCESS   NONE/R/W/X; R and X are both reads
//  db_memLen      in   `MEM_LEN      `MEM_LEN_B / `MEM_LEN_H / `MEM_LEN_W
//  db_dataIn      out  32            read data, right-aligned, zero-extended; valid only when db_ready=1
//  db_ready       out  1             one-cycle completion pulse
//  db_misalign    out  1             with db_ready: access rejected as misaligned
//  db_err         out  1             with db_ready: access aborted by timeout (0 without BUS_TIMEOUT_EN)
//  mem_req        out  1             memory request, held until mem_ack
//  mem_we         out  1             1 = write
//  mem_addr       out  ADDR_WIDTH-2  word address
//  mem_be         out  4             byte enables, bit i = bits [8i+7:8i]
//  mem_wdata      out  32            lane-replicated write data
//  mem_rdata      in   32            read word, valid in the mem_ack cycle
//  mem_ack        in   1             completes the held request
// BEHAVIOUR
//  - Reset (res=0 at posedge): state=IDLE; every output 0; any in-flight mem_req drops after that
//    edge; no db_ready is produced for the aborted access.
//  - FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE; IDLE -> DONE directly on misalignment.
//  - IDLE: accept when db_accessType != `MEM_ACCESS_NONE. Latch addr, len, write flag, data.
//    Aligned: -> REQ. Misaligned (H with addr[0]=1, W with addr[1:0]!=0): -> DONE, no memory access.
//  - REQ (1 cycle): mem_req=1 with mem_we/addr/be/wdata from registers; -> WAIT.
//    If mem_ack=1 here, capture and -> DONE.
//  - WAIT: mem_req and all mem_* outputs held stable; on mem_ack capture mem_rdata, -> DONE.
//  - DONE (1 cycle): db_ready=1; db_misalign/db_err reflect the cause; mem_req=0; -> IDLE.
//    db_accessType is ignored in DONE; a new request is accepted from the following IDLE cycle.
//  - Latency: accept at cycle 0, mem_req at 1; ack at cycle k>=1 gives db_ready at k+1 (min 2).
//    Misaligned: db_ready at cycle 1.
//  - Byte enables: B -> 4'b0001<<a[1:0]; H -> 4'b0011<<{a[1],1'b0}; W -> 4'b1111.
//  - mem_wdata: B -> {4{d[7:0]}}; H -> {2{d[15:0]}}; W -> d. Reads drive mem_be as above, mem_we=0.
//  - Read data: B -> {24'b0, rdata byte a[1:0]}; H -> {16'b0, rdata half a[1]}; W -> rdata.
//    Misaligned or timeout: db_dataIn = 0.
//  - mem_ack outside REQ/WAIT is ignored. db_addr above ADDR_WIDTH aliases silently.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: counter cleared on REQ entry, +1 per WAIT cycle without ack.
//    When count == TIMEOUT_CYCLES: drop mem_req, -> DONE with db_err=1, db_dataIn=0.
//    An ack in the same cycle takes priority, so the access completes normally.
//  BUS_TIMEOUT_EN undefined: no counter, db_err tied 0, WAIT lasts until mem_ack.
// TESTING
//  1 Reset: res=0 for 2 cycles with mem_ack toggling -> all outputs 0, no db_ready.
//  2 Word read 0x0000_0104, mem_ack on cycle 3, mem_rdata=0x1234_5678 -> mem_addr=0x41,
//    mem_be=4'hF, db_ready at cycle 4, db_dataIn=0x1234_5678.
//  3 Byte write 0x0000_0103, db_dataOut=0x0000_00AB, ack same cycle as req -> mem_we=1,
//    mem_be=4'b1000, mem_wdata=0xABAB_ABAB, db_ready at cycle 2.
//  4 Half read 0x0000_0002, mem_rdata=0xBEEF_1234 -> db_dataIn=0x0000_BEEF. Then half write
//    0x0000_0003 -> no mem_req, db_ready+db_misalign at cycle 1.
//  5 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req drops, db_ready+db_err=1,
//    db_dataIn=0. Repeat with ack on the limit cycle -> normal completion, db_err=0.
//  6 res=0 while in WAIT -> mem_req=0 after that edge, IDLE. Next word read completes normally.

Source files
------------

// File: rtl/db_mem_bridge.sv
// db_mem_bridge: data-bus slave turning one CPU access into one word-wide memory req/ack transaction.
// Latency: accept at cycle 0, mem_req from cycle 1, db_ready one cycle after mem_ack (misaligned: cycle 1).
// Backpressure: mem_req is held with stable mem_* until mem_ack; optional BUS_TIMEOUT_EN aborts a stuck WAIT.

`ifndef MEM_ACCESS
`define MEM_ACCESS      1:0
`define MEM_ACCESS_NONE 2'd0
`define MEM_ACCESS_R    2'd1
`define MEM_ACCESS_W    2'd2
`define MEM_ACCESS_X    2'd3
`endif
`ifndef MEM_LEN
`define MEM_LEN         1:0
`define MEM_LEN_B       2'd0
`define MEM_LEN_H       2'd1
`define MEM_LEN_W       2'd2
`endif

module db_mem_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [31:0]             db_addr,
  input  logic [31:0]             db_dataOut,
  input  logic [`MEM_ACCESS]      db_accessType,
  input  logic [`MEM_LEN]         db_memLen,
  output logic [31:0]             db_dataIn,
  output logic                    db_ready,
  output logic                    db_misalign,
  output logic                    db_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-3:0]   mem_addr,
  output logic [3:0]              mem_be,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              len_q;
  logic                    we_q;
  logic [31:0]             wdat_q;
  logic [31:0]             rdat_q;
  logic                    mis_q;
  logic                    accept, capture, tmo;
  logic                    misal_in;
  logic [3:0]              be_cur;
  logic [31:0]             wdata_cur;

  // Alignment check on the live request, used only in the accept cycle.
  always_comb begin
    misal_in = 1'b0;
    case (db_memLen)
      `MEM_LEN_B: misal_in = 1'b0;
      `MEM_LEN_H: misal_in = db_addr[0];
      default:    misal_in = (db_addr[1:0] != 2'b00);
    endcase
  end

  // Lane steering for byte enables and replicated write data from the latched request.
  always_comb begin
    be_cur    = 4'b1111;
    wdata_cur = wdat_q;
    case (len_q)
      `MEM_LEN_B: begin
        be_cur    = 4'b0001 << addr_q[1:0];
        wdata_cur = {4{wdat_q[7:0]}};
      end
      `MEM_LEN_H: begin
        be_cur    = 4'b0011 << {addr_q[1], 1'b0};
        wdata_cur = {2{wdat_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Right-align and zero-extend the addressed lane(s) of the returned word.
  function automatic logic [31:0] steer(input logic [31:0] w, input logic [1:0] len,
                                        input logic [1:0] a);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (len)
      `MEM_LEN_B: steer = {24'b0, sh[7:0]};
      `MEM_LEN_H: steer = a[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
      default:    steer = w;
    endcase
  endfunction

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          unused_addr;
  assign unused_addr = ^db_addr[31:ADDR_WIDTH];
`else
  logic          unused_cfg;
  assign unused_cfg = ^{db_addr[31:ADDR_WIDTH], TIMEOUT_CYCLES[0]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic plus request/handshake strobes; an ack always beats a timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    tmo       = 1'b0;
    mem_req   = 1'b0;
    db_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (db_accessType != `MEM_ACCESS_NONE) begin
          accept    = 1'b1;
          state_nxt = misal_in ? DONE : REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TO_LIM) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        db_ready  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch at accept and read-data capture at ack; timeout leaves the data at zero.
  always_ff @(posedge clk) begin
    if (!res) begin
      addr_q <= '0;
      len_q  <= '0;
      we_q   <= 1'b0;
      wdat_q <= '0;
      rdat_q <= '0;
      mis_q  <= 1'b0;
    end else if (accept) begin
      addr_q <= db_addr[ADDR_WIDTH-1:0];
      len_q  <= db_memLen;
      we_q   <= (db_accessType == `MEM_ACCESS_W);
      wdat_q <= db_dataOut;
      rdat_q <= '0;
      mis_q  <= misal_in;
    end else if (capture) begin
      rdat_q <= we_q ? 32'b0 : steer(mem_rdata, len_q, addr_q[1:0]);
    end else if (tmo) begin
      rdat_q <= '0;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Wait-cycle counter, restarted for every new memory request; err flag set on abort.
  always_ff @(posedge clk) begin
    if (!res) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) err_q <= 1'b0;
      else if (tmo) err_q <= 1'b1;
      if (state_nxt == REQ) cnt_q <= '0;
      else if (state == WAIT && !mem_ack && !tmo) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign db_err = db_ready & err_q;
`else
  assign db_err = 1'b0;
`endif

  // Memory-side fields are only driven while a request is outstanding.
  assign mem_we      = mem_req & we_q;
  assign mem_addr    = mem_req ? addr_q[ADDR_WIDTH-1:2] : '0;
  assign mem_be      = mem_req ? be_cur : 4'b0000;
  assign mem_wdata   = mem_req ? wdata_cur : 32'b0;
  assign db_dataIn   = db_ready ? rdat_q : 32'b0;
  assign db_misalign = db_ready & mis_q;

endmodule

// File: tb/tb_db_mem_bridge.sv
// Self-checking bench for db_mem_bridge: table-driven accesses with a scoreboard queue,
// plus hand-written reset, reset-in-WAIT and (with BUS_TIMEOUT_EN) timeout sequences.
module tb_db_mem_bridge;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] db_addr, db_dataOut, db_dataIn, mem_wdata, mem_rdata;
  logic [1:0]  db_accessType, db_memLen;
  logic        db_ready, db_misalign, db_err, mem_req, mem_we, mem_ack;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  db_mem_bridge #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .res(res), .db_addr(db_addr), .db_dataOut(db_dataOut),
    .db_accessType(db_accessType), .db_memLen(db_memLen), .db_dataIn(db_dataIn),
    .db_ready(db_ready), .db_misalign(db_misalign), .db_err(db_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic [1:0]  acc;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] dout;
    int          ack_cyc;   // cycle after accept in which mem_ack is driven; 0 = never
    logic [31:0] rdata;
    int          rdy_cyc;
    logic        we;
    logic [3:0]  be;
    logic [13:0] maddr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        mis;
    logic        err;
  } vec_t;

  vec_t vecs[10];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] acc, input logic [1:0] len,
                              input logic [31:0] addr, input logic [31:0] dout,
                              input int ack_cyc, input logic [31:0] rdata, input int rdy_cyc,
                              input logic we, input logic [3:0] be, input logic [13:0] maddr,
                              input logic [31:0] wdata, input logic [31:0] data,
                              input logic mis, input logic err);
    vec_t v;
    v.acc = acc; v.len = len; v.addr = addr; v.dout = dout; v.ack_cyc = ack_cyc;
    v.rdata = rdata; v.rdy_cyc = rdy_cyc; v.we = we; v.be = be; v.maddr = maddr;
    v.wdata = wdata; v.data = data; v.mis = mis; v.err = err;
    return v;
  endfunction

  // One access: push expectation, drive for one cycle, then step cycles until db_ready.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    bit   got;
    got = 1'b0;
    sb_q.push_back(v);
    @(negedge clk);
    db_accessType = v.acc; db_memLen = v.len; db_addr = v.addr; db_dataOut = v.dout;
    @(negedge clk);
    db_accessType = 2'd0;
    for (int c = 1; c <= 50 && !got; c++) begin
      if (db_ready) begin
        got = 1'b1;
        mem_ack = 1'b0;
        chk({tag, ".rdy_cyc"}, 32'(c), 32'(v.rdy_cyc));
        chk({tag, ".req_in_done"}, {31'b0, mem_req}, 32'd0);
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL %s.scoreboard: got unexpected db_ready required none", tag);
        end else begin
          e = sb_q.pop_front();
          chk({tag, ".data"}, db_dataIn, e.data);
          chk({tag, ".misalign"}, {31'b0, db_misalign}, {31'b0, e.mis});
          chk({tag, ".err"}, {31'b0, db_err}, {31'b0, e.err});
        end
      end else begin
        if (c == 1 || c == v.ack_cyc) begin
          chk({tag, ".req"}, {31'b0, mem_req}, 32'd1);
          chk({tag, ".we"}, {31'b0, mem_we}, {31'b0, v.we});
          chk({tag, ".maddr"}, {18'b0, mem_addr}, {18'b0, v.maddr});
          chk({tag, ".be"}, {28'b0, mem_be}, {28'b0, v.be});
          chk({tag, ".wdata"}, mem_wdata, v.wdata);
        end
        mem_ack   = (c == v.ack_cyc);
        mem_rdata = (c == v.ack_cyc) ? v.rdata : 32'hDEAD_0000;
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: got no db_ready required one within 50 cycles", tag);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end
  endtask

  initial begin
    // acc: 0 NONE 1 R 2 W 3 X ; len: 0 B 1 H 2 W
    vecs[0] = mk(2'd1, 2'd2, 32'h0000_0104, 32'h0, 3, 32'h1234_5678, 4,
                 1'b0, 4'hF, 14'h41, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    vecs[1] = mk(2'd2, 2'd0, 32'h0000_0103, 32'h0000_00AB, 1, 32'h0, 2,
                 1'b1, 4'b1000, 14'h40, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0);
    vecs[2] = mk(2'd1, 2'd1, 32'h0000_0002, 32'h0, 2, 32'hBEEF_1234, 3,
                 1'b0, 4'b1100, 14'h0, 32'h0, 32'h0000_BEEF, 1'b0, 1'b0);
    vecs[3] = mk(2'd2, 2'd1, 32'h0000_0003, 32'h0000_5555, 0, 32'h0, 1,
                 1'b0, 4'h0, 14'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vecs[4] = mk(2'd3, 2'd2, 32'h0000_0106, 32'h0, 0, 32'h0, 1,
                 1'b0, 4'h0, 14'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vecs[5] = mk(2'd3, 2'd0, 32'h0001_0005, 32'h0, 1, 32'hA1B2_C3D4, 2,
                 1'b0, 4'b0010, 14'h1, 32'h0, 32'h0000_00C3, 1'b0, 1'b0);
    vecs[6] = mk(2'd2, 2'd1, 32'h0000_0202, 32'h1234_CAFE, 2, 32'h0, 3,
                 1'b1, 4'b1100, 14'h80, 32'hCAFE_CAFE, 32'h0, 1'b0, 1'b0);
    vecs[7] = mk(2'd2, 2'd2, 32'h0000_FFFC, 32'hDEAD_BEEF, 5, 32'h0, 6,
                 1'b1, 4'hF, 14'h3FFF, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    vecs[8] = mk(2'd1, 2'd0, 32'h0000_0007, 32'h0, 1, 32'h89AB_CDEF, 2,
                 1'b0, 4'b1000, 14'h1, 32'h0, 32'h0000_0089, 1'b0, 1'b0);
    vecs[9] = mk(2'd1, 2'd1, 32'h0000_0000, 32'h0, 1, 32'hBEEF_1234, 2,
                 1'b0, 4'b0011, 14'h0, 32'h0, 32'h0000_1234, 1'b0, 1'b0);

    res = 1'b0; db_addr = '0; db_dataOut = '0; db_accessType = 2'd0; db_memLen = 2'd0;
    mem_rdata = 32'hFFFF_FFFF; mem_ack = 1'b0;

    // Reset held two cycles with mem_ack toggling: every output stays 0.
    @(negedge clk);
    chk("rst.ready", {31'b0, db_ready}, 32'd0);
    chk("rst.req", {31'b0, mem_req}, 32'd0);
    chk("rst.outs", {db_misalign, db_err, mem_we, mem_be, 18'b0, mem_addr} | db_dataIn | mem_wdata, 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("rst2.outs", {db_ready, mem_req, db_misalign, db_err, mem_we, mem_be, 9'b0, mem_addr}
                     | db_dataIn | mem_wdata, 32'd0);
    mem_ack = 1'b0;
    res = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for ack: request drops, no completion for the aborted access.
    @(negedge clk);
    db_accessType = 2'd1; db_memLen = 2'd2; db_addr = 32'h0000_0300;
    @(negedge clk);
    db_accessType = 2'd0;
    @(negedge clk);
    chk("rstw.req_before", {31'b0, mem_req}, 32'd1);
    res = 1'b0;
    @(negedge clk);
    chk("rstw.req_after", {31'b0, mem_req}, 32'd0);
    chk("rstw.ready_after", {31'b0, db_ready}, 32'd0);
    res = 1'b1;
    @(negedge clk);
    chk("rstw.ready_idle", {31'b0, db_ready}, 32'd0);
    run_vec(vecs[0], "post_rst");

`ifdef BUS_TIMEOUT_EN
    // Limit of 4: WAIT cycles 2..6, abort decided in cycle 6, db_ready in cycle 7.
    run_vec(mk(2'd1, 2'd2, 32'h0000_0010, 32'h0, 0, 32'h0, 7,
               1'b0, 4'hF, 14'h4, 32'h0, 32'h0, 1'b0, 1'b1), "tmo");
    run_vec(mk(2'd1, 2'd2, 32'h0000_0010, 32'h0, 6, 32'h55AA_33CC, 7,
               1'b0, 4'hF, 14'h4, 32'h0, 32'h55AA_33CC, 1'b0, 1'b0), "tmo_ack");
`endif

    chk("sb.empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
